// File: rtl/fxyz_pkg.sv
// fxyz_pkg: shared FSM state type and sizing constants for the fxyz sweep controller
package fxyz_pkg;

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        SAMPLE,
        DONE
    } sweep_state_t;

    localparam int N_VEC    = 8;
    localparam int VEC_W    = 3;
    localparam int CNT_W    = 4;
    localparam int SETTLE_W = 4;

endpackage

// File: rtl/fxyz.sv
// fxyz: two-output boolean datapath, s1 unsimplified and s2 simplified form of one function
module fxyz (
    input  logic x,
    input  logic y,
    input  logic z,
    output logic s1,
    output logic s2
);

    assign s1 = (~x & ~y & z) | (~x & y & z) | (x & y & z);
    assign s2 = z & (~x | y);

endmodule

// File: rtl/fxyz_sweep_top.sv
// fxyz_sweep_top: integration of the sweep controller with the fxyz datapath it checks
module fxyz_sweep_top
    import fxyz_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [N_VEC-1:0] tt_s1,
    output logic [N_VEC-1:0] tt_s2,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic             equal
);

    logic w_x;
    logic w_y;
    logic w_z;
    logic w_s1;
    logic w_s2;

    fxyz_sweep_ctrl #(.SETTLE(SETTLE)) u_ctrl (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .x            (w_x),
        .y            (w_y),
        .z            (w_z),
        .s1           (w_s1),
        .s2           (w_s2),
        .busy         (busy),
        .done         (done),
        .tt_s1        (tt_s1),
        .tt_s2        (tt_s2),
        .mismatch_cnt (mismatch_cnt),
        .equal        (equal)
    );

    fxyz u_fxyz (
        .x  (w_x),
        .y  (w_y),
        .z  (w_z),
        .s1 (w_s1),
        .s2 (w_s2)
    );

endmodule

// File: rtl/fxyz_sweep_ctrl.sv
// fxyz_sweep_ctrl: exhaustive 8-vector sweep of fxyz with truth-table capture and s1/s2 equivalence count
module fxyz_sweep_ctrl
    import fxyz_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             x,
    output logic             y,
    output logic             z,
    input  logic             s1,
    input  logic             s2,
    output logic             busy,
    output logic             done,
    output logic [N_VEC-1:0] tt_s1,
    output logic [N_VEC-1:0] tt_s2,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic             equal
);

    if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
        $error("fxyz_sweep_ctrl: SETTLE must be in 1..15");
    end

    sweep_state_t        r_state;
    sweep_state_t        w_next;
    logic [VEC_W-1:0]    r_vec;
    logic [SETTLE_W-1:0] r_cnt;
    logic [N_VEC-1:0]    r_tt1;
    logic [N_VEC-1:0]    r_tt2;
    logic [CNT_W-1:0]    r_mis;
    logic                r_eq;
    logic                w_settled;
    logic                w_last;

    assign w_settled = r_cnt == SETTLE_W'(SETTLE - 1);
    assign w_last    = r_vec == VEC_W'(N_VEC - 1);

    // state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // next-state logic: hold each vector SETTLE cycles, sample once, stop after the last vector
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = start ? APPLY : IDLE;
            APPLY:   w_next = w_settled ? SAMPLE : APPLY;
            SAMPLE:  w_next = w_last ? DONE : APPLY;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // outputs decoded from state; the stimulus follows the vector index, which parks at 7 after a sweep
    always_comb begin
        busy         = (r_state == APPLY) || (r_state == SAMPLE);
        done         = r_state == DONE;
        {x, y, z}    = r_vec;
        tt_s1        = r_tt1;
        tt_s2        = r_tt2;
        mismatch_cnt = r_mis;
        equal        = r_eq;
    end

    // datapath: results are cleared only when a sweep is accepted so they persist through IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vec <= '0;
            r_cnt <= '0;
            r_tt1 <= '0;
            r_tt2 <= '0;
            r_mis <= '0;
            r_eq  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_vec <= '0;
                        r_cnt <= '0;
                        r_tt1 <= '0;
                        r_tt2 <= '0;
                        r_mis <= '0;
                        r_eq  <= 1'b0;
                    end
                end
                APPLY: begin
                    if (!w_settled) r_cnt <= r_cnt + 1'b1;
                end
                SAMPLE: begin
                    r_tt1[r_vec] <= s1;
                    r_tt2[r_vec] <= s2;
                    if (s1 != s2) r_mis <= r_mis + 1'b1;
                    if (!w_last) begin
                        r_vec <= r_vec + 1'b1;
                        r_cnt <= '0;
                    end
                end
                DONE: begin
                    r_eq <= r_mis == '0;
                end
                default: begin
                    r_eq <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fxyz_sweep_ctrl.sv
// tb_fxyz_sweep_ctrl: directed checks of the fxyz sweep controller, standalone and integrated
module tb_fxyz_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       st  = 1'b0;
    logic       f0  = 1'b0;
    logic [1:0] sel = 2'd0;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         d_at, b_n, d_n;
    int         v_err;
    logic [2:0] vlog [1:45];

    always #5 clk = ~clk;

    logic       xa, ya, za, s1a, s2a, busya, donea, eqa;
    logic [7:0] t1a, t2a;
    logic [3:0] ma;
    logic       xb, yb, zb, s1b, s2b, busyb, doneb, eqb;
    logic [7:0] t1b, t2b;
    logic [3:0] mb;
    logic       busyc, donec, eqc;
    logic [7:0] t1c, t2c;
    logic [3:0] mc;

    assign s1a = (~xa & za) | (ya & za);
    assign s2a = f0 ? 1'b0 : s1a;
    assign s1b = (~xb & zb) | (yb & zb);
    assign s2b = s1b;

    fxyz_sweep_ctrl #(.SETTLE(1)) u_dut (
        .clk(clk), .rst(rst), .start(st && sel == 2'd0),
        .x(xa), .y(ya), .z(za), .s1(s1a), .s2(s2a),
        .busy(busya), .done(donea), .tt_s1(t1a), .tt_s2(t2a),
        .mismatch_cnt(ma), .equal(eqa)
    );

    fxyz_sweep_ctrl #(.SETTLE(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(st && sel == 2'd1),
        .x(xb), .y(yb), .z(zb), .s1(s1b), .s2(s2b),
        .busy(busyb), .done(doneb), .tt_s1(t1b), .tt_s2(t2b),
        .mismatch_cnt(mb), .equal(eqb)
    );

    fxyz_sweep_top #(.SETTLE(1)) u_top (
        .clk(clk), .rst(rst), .start(st && sel == 2'd2),
        .busy(busyc), .done(donec), .tt_s1(t1c), .tt_s2(t2c),
        .mismatch_cnt(mc), .equal(eqc)
    );

    logic       busy_m, done_m, eq_m;
    logic [7:0] t1_m, t2_m;
    logic [3:0] m_m;
    logic [2:0] xyz_m;

    assign busy_m = sel == 2'd0 ? busya : sel == 2'd1 ? busyb : busyc;
    assign done_m = sel == 2'd0 ? donea : sel == 2'd1 ? doneb : donec;
    assign eq_m   = sel == 2'd0 ? eqa   : sel == 2'd1 ? eqb   : eqc;
    assign t1_m   = sel == 2'd0 ? t1a   : sel == 2'd1 ? t1b   : t1c;
    assign t2_m   = sel == 2'd0 ? t2a   : sel == 2'd1 ? t2b   : t2c;
    assign m_m    = sel == 2'd0 ? ma    : sel == 2'd1 ? mb    : mc;
    assign xyz_m  = sel == 2'd1 ? {xb, yb, zb} : {xa, ya, za};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_results(input string tag, input logic [7:0] e1, input logic [7:0] e2,
                               input logic [3:0] em, input logic ee);
        chk({tag, ".tt_s1"}, 32'(t1_m), 32'(e1));
        chk({tag, ".tt_s2"}, 32'(t2_m), 32'(e2));
        chk({tag, ".mismatch_cnt"}, 32'(m_m), 32'(em));
        chk({tag, ".equal"}, 32'(eq_m), 32'(ee));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".xyz"}, 32'(xyz_m), 32'd0);
        chk({tag, ".busy"}, 32'(busy_m), 32'd0);
        chk({tag, ".done"}, 32'(done_m), 32'd0);
        chk_results(tag, 8'h00, 8'h00, 4'd0, 1'b0);
    endtask

    task automatic sweep(input bit rp, output int o_at, output int o_busy, output int o_done);
        o_at = 0;
        o_busy = 0;
        o_done = 0;
        st = 1'b1;
        tick();
        st = 1'b0;
        for (int c = 1; c <= 45; c++) begin
            if (busy_m) o_busy++;
            if (done_m) begin
                o_done++;
                if (o_at == 0) o_at = c;
            end
            vlog[c] = xyz_m;
            st = rp && (c == 5 || c == 16);
            tick();
        end
        st = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        tick();
        tick();
        sel = 2'd0;
        chk_reset("reset");
        rst = 1'b0;
        tick();

        sel = 2'd2;
        sweep(1'b0, d_at, b_n, d_n);
        chk("top.done_cycle", 32'(d_at), 32'd17);
        chk("top.busy_cycles", 32'(b_n), 32'd16);
        chk("top.done_count", 32'(d_n), 32'd1);
        chk_results("top", 8'h8A, 8'h8A, 4'd0, 1'b1);

        sel = 2'd0;
        f0 = 1'b1;
        sweep(1'b0, d_at, b_n, d_n);
        chk("s2zero.done_cycle", 32'(d_at), 32'd17);
        chk_results("s2zero", 8'h8A, 8'h00, 4'd3, 1'b0);
        f0 = 1'b0;

        sel = 2'd1;
        sweep(1'b0, d_at, b_n, d_n);
        v_err = 0;
        for (int c = 1; c <= 32; c++) if (vlog[c] !== 3'((c - 1) / 4)) v_err++;
        chk("settle3.vector_order", 32'(v_err), 32'd0);
        chk("settle3.done_cycle", 32'(d_at), 32'd33);
        chk("settle3.busy_cycles", 32'(b_n), 32'd32);
        chk("settle3.xyz_after", 32'(vlog[33]), 32'd7);
        chk_results("settle3", 8'h8A, 8'h8A, 4'd0, 1'b1);

        sel = 2'd0;
        sweep(1'b1, d_at, b_n, d_n);
        chk("repulse.done_cycle", 32'(d_at), 32'd17);
        chk("repulse.done_count", 32'(d_n), 32'd1);
        chk("repulse.busy_cycles", 32'(b_n), 32'd16);
        chk_results("repulse", 8'h8A, 8'h8A, 4'd0, 1'b1);

        st = 1'b1;
        tick();
        st = 1'b0;
        repeat (8) tick();
        chk("midrst.vec4", 32'(xyz_m), 32'd4);
        chk("midrst.partial_tt", 32'(t1_m), 32'h0A);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset("midrst");
        tick();
        chk("midrst.idle_busy", 32'(busy_m), 32'd0);
        sweep(1'b0, d_at, b_n, d_n);
        chk("midrst.resweep_done", 32'(d_at), 32'd17);
        chk_results("midrst.resweep", 8'h8A, 8'h8A, 4'd0, 1'b1);

        rst = 1'b1;
        st = 1'b1;
        tick();
        rst = 1'b0;
        st = 1'b0;
        chk("rststart.busy", 32'(busy_m), 32'd0);
        tick();
        chk("rststart.still_idle", 32'(busy_m), 32'd0);
        sweep(1'b0, d_at, b_n, d_n);
        chk("rststart.done_cycle", 32'(d_at), 32'd17);
        chk("rststart.busy_cycles", 32'(b_n), 32'd16);
        chk_results("rststart", 8'h8A, 8'h8A, 4'd0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fxyz_sweep_ctrl.md
# fxyz_sweep_ctrl

Sequencer and self-check controller for the `fxyz` two-output boolean datapath (`s1` unsimplified, `s2` simplified form of the same function). On a `start` pulse it drives all eight `{x,y,z}` combinations in ascending order and lets each settle. It captures both outputs into 8-bit truth tables and counts vectors where `s1 != s2`. It then pulses `done`. It replaces the manual exhaustive stimulus with a clocked, reusable equivalence checker that sits beside `fxyz` at the top level.

## Interface
- `SETTLE`, default 1: cycles each vector is held before sampling. Legal range 1..15.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  sweep request; accepted only in IDLE.
- `x`, `y`, `z`  out  1 each  stimulus to `fxyz`, equal to `vec_idx[2]`, `vec_idx[1]`, `vec_idx[0]`.
- `s1`, `s2`  in  1 each  `fxyz` outputs.
- `busy`  out  1  high while sweeping (APPLY or SAMPLE).
- `done`  out  1  one-cycle pulse when the sweep completes.
- `tt_s1`, `tt_s2`  out  8  captured truth tables; bit i is the output for `{x,y,z} = i`.
- `mismatch_cnt`  out  4  number of vectors with `s1 != s2`, range 0..8.
- `equal`  out  1  high when the last completed sweep had `mismatch_cnt == 0`.

## Operation
- FSM states: IDLE, APPLY, SAMPLE, DONE.
- IDLE:
  - On `start`, go to APPLY.
  - Clear `vec_idx`, the settle counter, `tt_s1`, `tt_s2`, `mismatch_cnt` and `equal`.
- APPLY: drive `vec_idx` on `x,y,z`; after `SETTLE` cycles in APPLY, go to SAMPLE.
- SAMPLE:
  - Write `tt_s1[vec_idx] <= s1` and `tt_s2[vec_idx] <= s2`.
  - If `s1 != s2`, increment `mismatch_cnt`.
  - If `vec_idx == 7`, go to DONE. Otherwise increment `vec_idx`, reload the settle counter and go to APPLY.
- DONE:
  - Assert `done` for one cycle.
  - Set `equal <= (final mismatch_cnt == 0)`.
  - Go to IDLE. `x,y,z` hold 3'b111.
- `mismatch_cnt` is 4 bits and cannot wrap, since its maximum is 8.
- `start` while in APPLY, SAMPLE or DONE is ignored. It is not queued.
- Results hold in IDLE until the next accepted `start`.
- X or Z on `s1`/`s2` is not interpreted; the bench treats it as an error.

## Timing
- Reset values:
  - state IDLE, `vec_idx` 0
  - `x=y=z=0`, `busy=0`, `done=0`
  - `tt_s1=tt_s2=8'h00`, `mismatch_cnt=0`, `equal=0`
- `rst` mid-sweep aborts at the next edge and restores all reset values. There is no partial-result retention.
- Simultaneous `rst` and `start`: `rst` wins.
- Sweep cadence:
  - `start` sampled at edge k puts the FSM in APPLY with vector 0 from cycle k+1.
  - Each vector occupies `SETTLE`+1 cycles.
  - DONE (`done=1`) falls in cycle k+1+8·(`SETTLE`+1).
  - `busy` is high exactly 8·(`SETTLE`+1) cycles.
- Sampling happens at the SAMPLE-cycle edge, i.e. `SETTLE` full cycles after the vector changes. `fxyz` is purely combinational, so `SETTLE`=1 suffices.
- A new `start` is accepted no earlier than the cycle after DONE.

## Structure
- Shared package `fxyz_pkg`:
  - state enum `sweep_state_t` (IDLE/APPLY/SAMPLE/DONE)
  - `N_VEC = 8`, `VEC_W = 3`, `CNT_W = 4`, `SETTLE_W = 4`
- No sub-module inside the controller; the FSM, counters and capture registers are flat.
- Natural integration wrapper `fxyz_sweep_top` instantiates `fxyz_sweep_ctrl` and `fxyz` and wires `x,y,z` and `s1,s2`.

## Test plan
- Reset, then `start` pulse through `fxyz_sweep_top` with `SETTLE`=1 → `tt_s1 = tt_s2 = 8'h8A`, `mismatch_cnt = 0`, `equal = 1`, `done` pulse 17 cycles after the start edge, `busy` high 16 cycles.
- Bench-driven `s1` per `fxyz`, `s2` forced to 0 → `tt_s1 = 8'h8A`, `tt_s2 = 8'h00`, `mismatch_cnt = 3`, `equal = 0`.
- `SETTLE`=3, `x,y,z` monitored → vectors 0..7 ascending, each held 4 cycles; `done` 33 cycles after the start edge.
- `start` re-pulsed at cycles 5 and 16 of a sweep → ignored; a single `done`; results identical to the first scenario.
- `rst` asserted during vector 4 → next cycle all outputs at reset values and state IDLE; a subsequent `start` gives the full correct sweep.
- `start` and `rst` in the same cycle → stays IDLE, `busy = 0`; `start` one cycle later begins the sweep normally.
